// File: rtl/uart_pkg.sv
// Shared state encoding and line constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic TX_IDLE = 1'b1;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic par_odd(input logic [1:0] mode);
        return mode == PAR_ODD;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: power-of-two depth, pointer-with-wrap-bit full/empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign empty = r_wr_ptr == r_rd_ptr;
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr = push && !full;
    assign w_rd = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with FIFO, optional parity, 1/2 stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              TX,
    output logic              wr_done,
    output logic              full,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        count
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W);

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    tx_state_e         r_state;
    logic [CW-1:0]     r_clk_cnt;
    logic [IW-1:0]     r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;
    logic              r_stop_idx;
    logic              r_tx;
    logic              r_wr_done;
    logic              r_overflow;
    logic [7:0]        r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_dout;

    assign w_push      = wr_en && !w_full;
    assign w_bit_end   = r_clk_cnt == BIT_LAST;
    assign w_last_stop = !r_stop2 || r_stop_idx;
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end && w_last_stop;
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= ST_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= TX_IDLE;
            r_wr_done  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_wr_done <= 1'b0;
            r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_ONE;
            // Raise done one edge early so it is high on the final stop cycle.
            if (r_state == ST_STOP && r_clk_cnt == BIT_PRE && w_last_stop) begin
                r_wr_done <= 1'b1;
                r_count   <= r_count + 8'd1;
            end
            if (w_pop) begin
                r_state    <= ST_START;
                r_tx       <= 1'b0;
                r_clk_cnt  <= '0;
                r_shift    <= w_dout;
                r_par_en   <= par_enabled(parity_mode);
                r_par_bit  <= (^w_dout) ^ par_odd(parity_mode);
                r_stop2    <= stop2;
                r_stop_idx <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_tx      <= TX_IDLE;
                        r_clk_cnt <= '0;
                    end
                    ST_START: begin
                        if (w_bit_end) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                            r_tx      <= r_shift[0];
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            if (r_bit_idx == IDX_LAST) begin
                                if (r_par_en) begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_par_bit;
                                end else begin
                                    r_state <= ST_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_ONE;
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_bit_end) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (w_bit_end) begin
                            if (w_last_stop) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_stop_idx <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= TX_IDLE;
                    end
                endcase
            end
        end
    end

    // A push refused for fullness is flagged even if a pop frees space.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
        end
    end

    assign TX       = r_tx;
    assign wr_done  = r_wr_done;
    assign overflow = r_overflow;
    assign count    = r_count;
    assign full     = w_full;
    assign busy     = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: frame monitor against queued items.
module tb_uart_tx_param;

    localparam int CPB = 4;

    typedef struct {
        logic [8:0] data;
        int         nbits;
        logic [1:0] pm;
        logic       s2;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       wr8   = 1'b0;
    logic       wr7   = 1'b0;
    logic [7:0] din8  = '0;
    logic [6:0] din7  = '0;
    logic [1:0] pm    = 2'b00;
    logic       s2    = 1'b0;

    logic       tx8, done8, full8, busy8, ovf8;
    logic [7:0] cnt8;
    logic       tx7, done7, full7, busy7, ovf7;
    logic [7:0] cnt7;

    uart_tx_param #(
        .DATA_W       (8),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr8),
        .data_in     (din8),
        .parity_mode (pm),
        .stop2       (s2),
        .TX          (tx8),
        .wr_done     (done8),
        .full        (full8),
        .busy        (busy8),
        .overflow    (ovf8),
        .count       (cnt8)
    );

    uart_tx_param #(
        .DATA_W       (7),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) u_dut7 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr7),
        .data_in     (din7),
        .parity_mode (pm),
        .stop2       (s2),
        .TX          (tx7),
        .wr_done     (done7),
        .full        (full7),
        .busy        (busy7),
        .overflow    (ovf7),
        .count       (cnt7)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    push_cyc = 0;
    int    cnt_exp[2];
    bit    mon_busy[2];
    item_t q8[$];
    item_t q7[$];
    int    st_log[$];
    int    en_log[$];
    int    done_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done8 || done7) done_log.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int s);
        return (s != 0) ? tx7 : tx8;
    endfunction

    function automatic logic done_of(input int s);
        return (s != 0) ? done7 : done8;
    endfunction

    function automatic logic busy_of(input int s);
        return (s != 0) ? busy7 : busy8;
    endfunction

    function automatic logic [7:0] cnt_of(input int s);
        return (s != 0) ? cnt7 : cnt8;
    endfunction

    function automatic int qsz(input int s);
        return (s != 0) ? q7.size() : q8.size();
    endfunction

    function automatic item_t qpop(input int s);
        if (s != 0) return q7.pop_front();
        return q8.pop_front();
    endfunction

    // Decode one frame from the line and compare it to the head item.
    task automatic mon(input int s);
        item_t          it;
        logic           exp_bits[$];
        logic [CPB-1:0] v;
        bit             abort;
        bit             early;
        forever begin
            @(negedge clk);
            if (rst_n || tx_of(s) !== 1'b0) continue;
            if (qsz(s) == 0) begin
                chk($sformatf("unexpected_frame_dut%0d", s), 32'd1, 32'd0);
                repeat (12 * CPB) @(negedge clk);
                continue;
            end
            mon_busy[s] = 1'b1;
            it = qpop(s);
            st_log.push_back(cyc);
            exp_bits = {};
            exp_bits.push_back(1'b0);
            for (int i = 0; i < it.nbits; i++) exp_bits.push_back(it.data[i]);
            if (it.pm == 2'b01) exp_bits.push_back(^it.data);
            if (it.pm == 2'b10) exp_bits.push_back(~^it.data);
            exp_bits.push_back(1'b1);
            if (it.s2) exp_bits.push_back(1'b1);
            abort = 1'b0;
            early = 1'b0;
            for (int b = 0; b < exp_bits.size() && !abort; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst_n) begin
                        abort = 1'b1;
                        break;
                    end
                    v[c] = tx_of(s);
                    if (b == exp_bits.size() - 1 && c == CPB - 1) begin
                        cnt_exp[s] = (cnt_exp[s] + 1) % 256;
                        chk("wr_done_last_cycle", done_of(s), 1);
                        chk("count_at_done", cnt_of(s), cnt_exp[s]);
                    end else if (done_of(s)) begin
                        early = 1'b1;
                    end
                end
                if (!abort) begin
                    chk($sformatf("dut%0d_bit%0d", s, b), v, {CPB{exp_bits[b]}});
                end
            end
            if (!abort) begin
                chk("wr_done_early", early, 0);
                en_log.push_back(cyc);
            end
            mon_busy[s] = 1'b0;
        end
    endtask

    task automatic push(input int s, input logic [8:0] d, input bit keep);
        item_t it;
        @(negedge clk);
        if (s != 0) begin
            wr7  = 1'b1;
            din7 = d[6:0];
        end else begin
            wr8  = 1'b1;
            din8 = d[7:0];
        end
        push_cyc = cyc;
        if (keep) begin
            it.data  = d;
            it.nbits = (s != 0) ? 7 : 8;
            it.pm    = pm;
            it.s2    = s2;
            if (s != 0) q7.push_back(it);
            else q8.push_back(it);
        end
    endtask

    task automatic release_wr();
        @(negedge clk);
        wr8 = 1'b0;
        wr7 = 1'b0;
    endtask

    task automatic wait_idle(input int s, input string tag);
        int n = 0;
        @(negedge clk);
        while (n < 1000 && (busy_of(s) || qsz(s) != 0 || mon_busy[s])) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < 1000), 1);
    endtask

    task automatic clear_logs();
        st_log   = {};
        en_log   = {};
        done_log = {};
    endtask

    function automatic int flen(input int i);
        if (i < st_log.size() && i < done_log.size())
            return done_log[i] - st_log[i] + 1;
        return -1;
    endfunction

    initial begin
        fork
            mon(0);
            mon(1);
        join_none
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        int  e0;
        int  s1;
        logic seen;
        cnt_exp = '{0, 0};
        mon_busy = '{0, 0};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx8, 1);
        chk("rst_wr_done", done8, 0);
        chk("rst_overflow", ovf8, 0);
        chk("rst_count", cnt8, 0);
        chk("rst_full", full8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_tx_dut7", tx7, 1);
        rst_n = 1'b0;

        // 8N1 frame of 0x69
        pm = 2'b00;
        s2 = 1'b0;
        clear_logs();
        push(0, 9'h069, 1'b1);
        t0 = push_cyc;
        release_wr();
        wait_idle(0, "idle_none");
        chk("start_latency", (st_log.size() > 0) ? st_log[0] - t0 : -1, 2);
        chk("len_none", flen(0), 40);
        chk("count_none", cnt8, 1);

        // even parity
        pm = 2'b01;
        clear_logs();
        push(0, 9'h069, 1'b1);
        release_wr();
        wait_idle(0, "idle_even");
        chk("len_even", flen(0), 44);

        // odd parity; mode changed mid-frame must not affect it
        pm = 2'b10;
        clear_logs();
        push(0, 9'h069, 1'b1);
        release_wr();
        repeat (10) @(negedge clk);
        pm = 2'b00;
        s2 = 1'b1;
        wait_idle(0, "idle_odd");
        chk("len_odd", flen(0), 44);
        chk("count_odd", cnt8, 3);

        // two stop bits, back-to-back frames
        pm = 2'b00;
        s2 = 1'b1;
        clear_logs();
        push(0, 9'h000, 1'b1);
        push(0, 9'h0FF, 1'b1);
        release_wr();
        wait_idle(0, "idle_stop2");
        chk("stop2_done_pulses", done_log.size(), 2);
        e0 = (en_log.size() > 0) ? en_log[0] : -10;
        s1 = (st_log.size() > 1) ? st_log[1] : -10;
        chk("stop2_contiguous", s1, e0 + 1);
        chk("len_stop2_a", flen(0), 44);
        chk("len_stop2_b", flen(1), 44);
        chk("count_stop2", cnt8, 5);

        // overflow on the 6th consecutive push
        s2 = 1'b0;
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            push(0, 9'(8'h10 + i), i < 5);
            if (i == 5) begin
                chk("full_before_6th", full8, 1);
                chk("no_ovf_yet", ovf8, 0);
            end
        end
        release_wr();
        chk("overflow_pulse", ovf8, 1);
        @(negedge clk);
        chk("overflow_one_cycle", ovf8, 0);
        wait_idle(0, "idle_overflow");
        chk("overflow_frames", done_log.size(), 5);
        chk("count_overflow", cnt8, 10);

        // reset during data bit 3, with a second word queued
        clear_logs();
        push(0, 9'h0A5, 1'b1);
        t0 = push_cyc;
        push(0, 9'h03C, 1'b1);
        release_wr();
        while (cyc < t0 + 19) @(negedge clk);
        chk("tx_bit3_before_rst", tx8, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx8, 1);
        chk("abort_busy", busy8, 0);
        chk("abort_count", cnt8, 0);
        chk("abort_wr_done", done8, 0);
        @(negedge clk);
        rst_n = 1'b0;
        q8.delete();
        cnt_exp = '{0, 0};
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen = seen | done8 | !tx8 | busy8;
        end
        chk("no_activity_after_rst", seen, 0);

        // 7O1 frame of 0x7F on the narrow instance
        pm = 2'b10;
        s2 = 1'b0;
        clear_logs();
        push(1, 9'h07F, 1'b1);
        release_wr();
        wait_idle(1, "idle_dw7");
        chk("len_dw7", flen(0), 40);
        chk("count_dw7", cnt7, 1);
        chk("count_dut8_quiet", cnt8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
